// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Read-side consumer for a dual-clock FIFO. It lives entirely in the read clock domain.
//   It pops the FIFO whenever there is buffer credit and the empty flag can be trusted.
//   Popped words are held in a 2-entry in-order buffer. The buffer is presented
//   downstream as a valid/ready stream.
//
// Parameters
//   WIDTH      data word width (must match the FIFO)
//   EMPTY_LAG  cycles after a read during which fifo_empty is stale (0 = exact)
//   COUNT_W    width of the delivered-word counter
//
// Ports
//   rclk        read-domain clock, rising edge
//   rrst_n      asynchronous active-low reset
//   fifo_empty  FIFO empty flag (rclk domain)
//   fifo_ren    FIFO read enable, one word per cycle high
//   fifo_rdata  FIFO read data, valid the cycle after fifo_ren
//   m_data      stream data (head of output buffer)
//   m_valid     stream valid
//   m_ready     stream ready from consumer
//   words_out   number of words accepted by the consumer (wraps)
module fifo_rd_stream #(
   parameter int WIDTH     = 8,
   parameter int EMPTY_LAG = 2,
   parameter int COUNT_W   = 16
) (
   input  logic               rclk,
   input  logic               rrst_n,
   input  logic               fifo_empty,
   output logic               fifo_ren,
   input  logic [WIDTH-1:0]   fifo_rdata,
   output logic [WIDTH-1:0]   m_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [COUNT_W-1:0] words_out
);

   localparam int HOLD_W = (EMPTY_LAG < 1) ? 1 : $clog2(EMPTY_LAG + 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(EMPTY_LAG);

   logic [1:0]         occ_q, occ_d;
   logic               inflight_q, inflight_d;
   logic [HOLD_W-1:0]  holdoff_q, holdoff_d;
   logic [WIDTH-1:0]   head_q, head_d;
   logic [WIDTH-1:0]   tail_q, tail_d;
   logic [COUNT_W-1:0] words_q, words_d;

   logic               pop;
   logic               capture;
   logic               ren;
   logic [1:0]         credit_used;

   always_comb begin
      pop         = (occ_q != 2'd0) && m_ready;
      capture     = inflight_q;
      // Buffered words plus the word on its way. This count never exceeds 2.
      credit_used = occ_q + {1'b0, inflight_q};
      // A pop in this cycle frees a slot in time for the word read now.
      // This is the only m_ready -> fifo_ren combinational path.
      ren         = rrst_n && !fifo_empty && (holdoff_q == '0) &&
                    ((credit_used < 2'd2) || pop);

      occ_d      = occ_q;
      inflight_d = ren;
      holdoff_d  = holdoff_q;
      head_d     = head_q;
      tail_d     = tail_q;
      words_d    = words_q;

      // The empty flag cannot be trusted for EMPTY_LAG cycles after each read.
      if (ren) begin
         holdoff_d = HOLD_LOAD;
      end else if (holdoff_q != '0) begin
         holdoff_d = holdoff_q - HOLD_W'(1);
      end

      if (pop) begin
         words_d = words_q + COUNT_W'(1);
      end

      case ({capture, pop})
         2'b10: begin
            occ_d = occ_q + 2'd1;
            if (occ_q == 2'd0) begin
               head_d = fifo_rdata;
            end else begin
               tail_d = fifo_rdata;
            end
         end
         2'b01: begin
            occ_d  = occ_q - 2'd1;
            head_d = tail_q;
         end
         2'b11: begin
            // The head advances and the new word fills the freed position.
            // occ cannot be 0 here because pop needs a valid head.
            if (occ_q == 2'd1) begin
               head_d = fifo_rdata;
            end else begin
               head_d = tail_q;
               tail_d = fifo_rdata;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         holdoff_q  <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         words_q    <= '0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         holdoff_q  <= holdoff_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         words_q    <= words_d;
      end
   end

   assign fifo_ren  = ren;
   assign m_valid   = (occ_q != 2'd0);
   assign m_data    = head_q;
   assign words_out = words_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream.
// dut_a: EMPTY_LAG=0, COUNT_W=4. dut_b: EMPTY_LAG=2, COUNT_W=16.
// Each DUT is fed by a small FIFO model.
module tb_fifo_rd_stream;

   logic rclk   = 1'b0;
   logic rrst_n = 1'b1;
   always #5 rclk = ~rclk;

   // ---------------- DUT A ----------------
   logic       empty_a, ren_a, valid_a;
   logic       ready_a = 1'b0;
   logic [7:0] rdata_a = 8'hEE;
   logic [7:0] data_a;
   logic [3:0] words_a;

   fifo_rd_stream #(.WIDTH(8), .EMPTY_LAG(0), .COUNT_W(4)) dut_a (
      .rclk(rclk), .rrst_n(rrst_n), .fifo_empty(empty_a), .fifo_ren(ren_a),
      .fifo_rdata(rdata_a), .m_data(data_a), .m_valid(valid_a),
      .m_ready(ready_a), .words_out(words_a));

   // ---------------- DUT B ----------------
   logic        empty_b, ren_b, valid_b;
   logic        ready_b = 1'b1;
   logic [7:0]  rdata_b = 8'hEE;
   logic [7:0]  data_b;
   logic [15:0] words_b;

   fifo_rd_stream #(.WIDTH(8), .EMPTY_LAG(2), .COUNT_W(16)) dut_b (
      .rclk(rclk), .rrst_n(rrst_n), .fifo_empty(empty_b), .fifo_ren(ren_b),
      .fifo_rdata(rdata_b), .m_data(data_b), .m_valid(valid_b),
      .m_ready(ready_b), .words_out(words_b));

   // ---------------- FIFO models ----------------
   logic [7:0] mem_a [64];
   logic [7:0] mem_b [64];
   int wr_a = 0, rd_a = 0, under_a = 0;
   int wr_b = 0, rd_b = 0, under_b = 0;
   int iss_a = 0, pop_a = 0, iss_b = 0, pop_b = 0;
   logic e1_b = 1'b1, e2_b = 1'b1;

   assign empty_a = (wr_a == rd_a);
   assign empty_b = e2_b;   // empty flag seen two cycles late

   always @(posedge rclk) begin
      if (ren_a) begin
         if (rd_a == wr_a) under_a <= under_a + 1;
         rdata_a <= mem_a[rd_a % 64];
         rd_a    <= rd_a + 1;
      end else begin
         rdata_a <= 8'hEE;
      end
      if (ren_b) begin
         if (rd_b == wr_b) under_b <= under_b + 1;
         rdata_b <= mem_b[rd_b % 64];
         rd_b    <= rd_b + 1;
      end else begin
         rdata_b <= 8'hEE;
      end
      e1_b <= (wr_b == rd_b);
      e2_b <= e1_b;
   end

   // Reads issued minus words accepted. This equals buffered plus in-flight words.
   always @(posedge rclk) begin
      if (!rrst_n) begin
         iss_a <= 0; pop_a <= 0; iss_b <= 0; pop_b <= 0;
      end else begin
         if (ren_a) iss_a <= iss_a + 1;
         if (valid_a && ready_a) pop_a <= pop_a + 1;
         if (ren_b) iss_b <= iss_b + 1;
         if (valid_b && ready_b) pop_b <= pop_b + 1;
      end
   end

   // ---------------- checking helpers ----------------
   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge rclk);
      #2;
      chk("credit_a", 32'(((iss_a - pop_a) <= 2)), 32'd1);
      chk("credit_b", 32'(((iss_b - pop_b) <= 2)), 32'd1);
   endtask

   task automatic push_a(input logic [7:0] w);
      mem_a[wr_a % 64] = w;
      wr_a++;
   endtask

   task automatic push_b(input logic [7:0] w);
      mem_b[wr_b % 64] = w;
      wr_b++;
   endtask

   // ---------------- vector table for dut_a ----------------
   typedef struct {
      logic       rdy;
      logic       ren;
      logic       vld;
      logic [7:0] data;
      logic [3:0] words;
   } vec_t;

   vec_t tbl [18];

   task automatic apply_rows(input int lo, input int hi, input string tag);
      for (int i = lo; i <= hi; i++) begin
         ready_a = tbl[i].rdy;
         #1;
         chk($sformatf("%s_ren[%0d]", tag, i), 32'(ren_a), 32'(tbl[i].ren));
         chk($sformatf("%s_vld[%0d]", tag, i), 32'(valid_a), 32'(tbl[i].vld));
         if (tbl[i].vld) chk($sformatf("%s_data[%0d]", tag, i), 32'(data_a), 32'(tbl[i].data));
         chk($sformatf("%s_words[%0d]", tag, i), 32'(words_a), 32'(tbl[i].words));
         tick();
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int got;
      int er4 [7];
      int ev4 [7];
      int er5 [9];
      int ev5 [9];
      logic [7:0] ed5 [9];

      // Streaming: 4 words, m_ready high throughout.
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd0};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 8'h11, 4'd0};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'h22, 4'd1};
      tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'h33, 4'd2};
      tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'h44, 4'd3};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 4'd4};
      // Back-pressure: 5 words, consumer stalled and then released.
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 4'd4};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 4'd4};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h51, 4'd4};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h51, 4'd4};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h51, 4'd4};
      tbl[12] = '{1'b1, 1'b1, 1'b1, 8'h51, 4'd4};
      tbl[13] = '{1'b1, 1'b1, 1'b1, 8'h52, 4'd5};  // occ=1, inflight=1, pop: read allowed
      tbl[14] = '{1'b1, 1'b1, 1'b1, 8'h53, 4'd6};
      tbl[15] = '{1'b1, 1'b0, 1'b1, 8'h54, 4'd7};
      tbl[16] = '{1'b1, 1'b0, 1'b1, 8'h55, 4'd8};
      tbl[17] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'd9};

      er4 = '{0, 0, 1, 0, 0, 0, 0};
      ev4 = '{0, 0, 0, 0, 1, 0, 0};
      er5 = '{0, 0, 1, 0, 0, 1, 0, 0, 0};
      ev5 = '{0, 0, 0, 0, 1, 0, 0, 1, 0};
      ed5 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hB1, 8'h00, 8'h00, 8'hB2, 8'h00};

      // Reset state
      #1 rrst_n = 1'b0;
      ready_a = 1'b1;
      #2;
      chk("rst_ren_a", 32'(ren_a), 32'd0);
      chk("rst_vld_a", 32'(valid_a), 32'd0);
      chk("rst_data_a", 32'(data_a), 32'd0);
      chk("rst_words_a", 32'(words_a), 32'd0);
      chk("rst_vld_b", 32'(valid_b), 32'd0);
      chk("rst_words_b", 32'(words_b), 32'd0);
      tick();
      tick();
      rrst_n = 1'b1;
      tick();

      // Streaming
      push_a(8'h11); push_a(8'h22); push_a(8'h33); push_a(8'h44);
      apply_rows(0, 6, "stream");

      // Back-pressure
      ready_a = 1'b0;
      push_a(8'h51); push_a(8'h52); push_a(8'h53); push_a(8'h54); push_a(8'h55);
      apply_rows(7, 17, "bp");

      // Reset mid-stream: A1 is buffered, A2 is in flight, A3 stays in the FIFO.
      ready_a = 1'b0;
      push_a(8'hA1); push_a(8'hA2); push_a(8'hA3);
      #1 chk("mr_ren0", 32'(ren_a), 32'd1);
      tick();
      #1 chk("mr_ren1", 32'(ren_a), 32'd1);
      chk("mr_vld1", 32'(valid_a), 32'd0);
      tick();
      #1 chk("mr_ren2", 32'(ren_a), 32'd0);
      chk("mr_vld2", 32'(valid_a), 32'd1);
      chk("mr_data2", 32'(data_a), 32'hA1);
      rrst_n = 1'b0;
      ready_a = 1'b1;
      #1;
      chk("mr_rst_ren", 32'(ren_a), 32'd0);
      chk("mr_rst_vld", 32'(valid_a), 32'd0);
      chk("mr_rst_data", 32'(data_a), 32'd0);
      chk("mr_rst_words", 32'(words_a), 32'd0);
      tick();
      #1 chk("mr_rst_ren_hold", 32'(ren_a), 32'd0);
      chk("mr_rst_vld_hold", 32'(valid_a), 32'd0);
      rrst_n = 1'b1;
      got = 0;
      for (int c = 0; c < 10 && got == 0; c++) begin
         #1;
         if (valid_a) begin
            chk("mr_first_after_rst", 32'(data_a), 32'hA3);
            got = 1;
         end
         tick();
      end
      chk("mr_seen", 32'(got), 32'd1);
      #1 chk("mr_words", 32'(words_a), 32'd1);
      chk("mr_vld_end", 32'(valid_a), 32'd0);
      tick();

      // Counter wrap: 16 more words bring the total to 17, so the 4-bit counter reads 1.
      for (int i = 0; i < 16; i++) push_a(8'h60 + 8'(i));
      got = 0;
      for (int c = 0; c < 60 && got < 16; c++) begin
         #1;
         if (valid_a) begin
            chk($sformatf("wrap_data[%0d]", got), 32'(data_a), 32'h60 + 32'(got));
            got++;
         end
         tick();
      end
      chk("wrap_count_seen", 32'(got), 32'd16);
      #1 chk("wrap_words", 32'(words_a), 32'd1);
      tick();

      // Empty lag: one word with a two-cycle-stale empty flag.
      ready_b = 1'b1;
      push_b(8'h5A);
      for (int k = 0; k < 7; k++) begin
         #1;
         chk($sformatf("lag1_ren[%0d]", k), 32'(ren_b), 32'(er4[k]));
         chk($sformatf("lag1_vld[%0d]", k), 32'(valid_b), 32'(ev4[k]));
         if (ev4[k] != 0) chk($sformatf("lag1_data[%0d]", k), 32'(data_b), 32'h5A);
         tick();
      end
      #1 chk("lag1_words", 32'(words_b), 32'd1);

      // Empty lag: two words. Reads must be at least 3 cycles apart.
      push_b(8'hB1); push_b(8'hB2);
      for (int k = 0; k < 9; k++) begin
         #1;
         chk($sformatf("lag2_ren[%0d]", k), 32'(ren_b), 32'(er5[k]));
         chk($sformatf("lag2_vld[%0d]", k), 32'(valid_b), 32'(ev5[k]));
         if (ev5[k] != 0) chk($sformatf("lag2_data[%0d]", k), 32'(data_b), 32'(ed5[k]));
         tick();
      end
      #1 chk("lag2_words", 32'(words_b), 32'd3);

      chk("underflow_a", 32'(under_a), 32'd0);
      chk("underflow_b", 32'(under_b), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
